mem_access_unit: RTL
====================

# mem_access_unit

Multi-cycle, parametrised load/store unit sitting between the MEM pipeline stage and the data-memory bus. It accepts one load/store per handshake and translates it into one or two bus beats with byte strobes. It realigns and sign/zero-extends load data and returns a single response. Accesses that cross a bus word are either split into two beats or faulted, selected by parameter.

## Interface
- `BUS_W`, 32: data-bus width in bits; legal values are 32 and 64.
- `ADDR_W`, 32: byte-address width.
- `SPLIT_MISALIGNED`, 1: 1 splits bus-crossing accesses into two beats; 0 faults every non-naturally-aligned access.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_sl_type` in 4: bit3 = store, bit2 = unsigned, [1:0] = size (00 NOP, 01 byte, 10 half, 11 word).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `rsp_valid` out 1: one-cycle completion pulse; there is no backpressure.
- `rsp_rdata` out 32: extended load data; 0 for stores, NOP and faults.
- `rsp_misaligned` out 1: fault flag, qualified by `rsp_valid`.
- `mem_req_valid` out 1 / `mem_req_ready` in 1: bus request handshake.
- `mem_we` out 1: write enable.
- `mem_addr` out ADDR_W: address, always aligned to BUS_W/8.
- `mem_wdata` out BUS_W: write data.
- `mem_wstrb` out BUS_W/8: byte write strobes.
- `mem_rsp_valid` in 1 / `mem_rdata` in BUS_W: bus response. Every beat, load or store, gets exactly one response.

## Operation
- **FSM states:** IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, latch type, address and data.
  - Go to RESP for a NOP or a fault; otherwise go to REQ0.
- **Offset and crossing:**
  - off = addr mod (BUS_W/8); nbytes = 1, 2 or 4.
  - The access crosses when off + nbytes > BUS_W/8.
- **Fault (SPLIT_MISALIGNED=0):**
  - Raised when addr is not a multiple of nbytes.
  - No bus traffic; the response carries `rsp_misaligned`=1 and `rsp_rdata`=0.
- **Store lanes:**
  - Form the 2·BUS_W value {0, wdata} << 8·off and the 2·BUS_W/8-bit strobe ((1<<nbytes)-1) << off.
  - Beat 0 carries the low halves; beat 1 carries the high halves.
- **Load lanes:**
  - Capture beat 0 data, and beat 1 data if crossing.
  - rdata = ({beat1, beat0} >> 8·off), truncated to nbytes.
  - Sign-extend when bit2=0, zero-extend when bit2=1.
- **Beat addresses:**
  - Beat 0 uses the aligned address.
  - Beat 1 uses aligned + BUS_W/8, wrapping modulo 2^ADDR_W.
  - `mem_we` equals bit3.
- **Transitions:**
  - REQ0 → WAIT0 on `mem_req_ready`.
  - WAIT0 → REQ1 on `mem_rsp_valid` if crossing, else → RESP.
  - REQ1 → WAIT1 on `mem_req_ready`.
  - WAIT1 → RESP on `mem_rsp_valid`.
  - RESP → IDLE unconditionally.
- `mem_rsp_valid` is ignored outside WAIT0 and WAIT1.

## Timing
- **Reset values:**
  - State IDLE, `req_ready`=1.
  - All other outputs 0: `rsp_valid`, `rsp_rdata`, `rsp_misaligned`, `mem_req_valid`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`.
- **Bus request signals:**
  - `mem_req_valid` is high exactly in REQ0 and REQ1.
  - Address, data and strobe stay stable until `mem_req_ready`.
- **Response latency**, request accepted at cycle t, with zero-wait memory (ready=1, response in the cycle after acceptance):
  - single-beat access: `rsp_valid` at t+3;
  - two-beat access: t+5;
  - NOP or fault: t+1.
- Each bus wait cycle (ready low, or response delayed) adds one cycle of latency.
- Only one request is in flight: `req_ready`=0 from t+1 until the cycle after RESP.
- **Reset mid-operation:**
  - `rst` in any state forces IDLE on the next edge, with `mem_req_valid`=0 and no `rsp_valid`.
  - A stale `mem_rsp_valid` arriving after reset is dropped.

## Structure
- **Package `lsu_pkg`:**
  - sl_type field positions;
  - size encodings MEM_NOP, MEM_B, MEM_H, MEM_W;
  - FSM state enum;
  - helper function for nbytes.
- **Sub-module `mem_lane_align`:** combinational, parametrised by BUS_W. It produces the shifted store data and strobes for both beats, and the extracted, extended load word. The FSM and registers stay in `mem_access_unit`.

## Test plan
BUS_W=32 and zero-wait memory unless stated otherwise.
- **Aligned load:** LW at 0x100, memory returns 0xDEADBEEF → one beat at `mem_addr`=0x100; `rsp_valid` at t+3 with `rsp_rdata`=0xDEADBEEF.
- **Byte extension:** LB at 0x103, rdata 0x80FFFFFF → 0xFFFFFF80; LBU at the same address → 0x00000080.
- **Halfword store:** SH at 0x102, wdata 0x0000ABCD → `mem_addr` 0x100, `mem_wstrb` 1100, `mem_wdata` 0xABCD0000, `mem_we`=1.
- **Split store (SPLIT=1):** SW at 0x103, wdata 0x11223344 →
  - beat 0: 0x100, strobe 1000, data 0x44000000;
  - beat 1: 0x104, strobe 0111, data 0x00112233;
  - `rsp_valid` at t+5.
- **Split load and fault:**
  - SPLIT=1: LH at 0x107, beats 0xAABBCCDD then 0x11223344 → 0x000044AA.
  - SPLIT=0: LH at 0x101 → `rsp_valid` and `rsp_misaligned` at t+1, with no `mem_req_valid` ever.
- **Reset and wrap:**
  - Hold `mem_req_ready`=0 for 3 cycles, then pulse `rst` → next cycle `mem_req_valid`=0, `req_ready`=1, no response.
  - SW at 0xFFFFFFFE with SPLIT=1 → beat 1 at `mem_addr` 0x00000000.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings, FSM states and helpers for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // sl_type field positions: [3] store, [2] unsigned, [1:0] size
    localparam int SL_STORE    = 3;
    localparam int SL_UNSIGNED = 2;

    localparam logic [1:0] MEM_NOP = 2'b00;
    localparam logic [1:0] MEM_B   = 2'b01;
    localparam logic [1:0] MEM_H   = 2'b10;
    localparam logic [1:0] MEM_W   = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ0  = 3'd1,
        WAIT0 = 3'd2,
        REQ1  = 3'd3,
        WAIT1 = 3'd4,
        RESP  = 3'd5
    } lsu_state_e;

    function automatic logic [2:0] lsu_nbytes(input logic [1:0] size);
        case (size)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            MEM_W:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Byte-lane shifter: store data/strobes for two beats, load extract.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import lsu_pkg::*;
#(
    parameter int BUS_W = 32
) (
    input  logic [$clog2(BUS_W/8)-1:0] off,
    input  logic [1:0]                 size,
    input  logic                       is_unsigned,
    input  logic [31:0]                wdata,
    input  logic [BUS_W-1:0]           beat0,
    input  logic [BUS_W-1:0]           beat1,
    output logic [BUS_W-1:0]           st_data0,
    output logic [BUS_W-1:0]           st_data1,
    output logic [BUS_W/8-1:0]         st_strb0,
    output logic [BUS_W/8-1:0]         st_strb1,
    output logic [31:0]                ld_data
);

    localparam int c_NB    = BUS_W / 8;
    localparam int c_OFF_W = $clog2(c_NB);

    logic [c_OFF_W+2:0]   w_shamt;
    logic [3:0]           w_mask;
    logic [2*BUS_W-1:0]   w_st_wide;
    logic [2*c_NB-1:0]    w_strb_wide;
    logic [31:0]          w_raw;

    assign w_shamt = {off, 3'b000};

    always_comb begin
        w_mask = 4'b0000;
        case (size)
            MEM_B:   w_mask = 4'b0001;
            MEM_H:   w_mask = 4'b0011;
            MEM_W:   w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    // Shift across a double-width window; the upper half belongs to beat 1
    assign w_st_wide   = {{(2*BUS_W-32){1'b0}}, wdata} << w_shamt;
    assign w_strb_wide = {{(2*c_NB-4){1'b0}}, w_mask} << off;

    assign {st_data1, st_data0} = w_st_wide;
    assign {st_strb1, st_strb0} = w_strb_wide;

    assign w_raw = 32'({beat1, beat0} >> w_shamt);

    always_comb begin
        ld_data = '0;
        case (size)
            MEM_B:   ld_data = {{24{~is_unsigned & w_raw[7]}},  w_raw[7:0]};
            MEM_H:   ld_data = {{16{~is_unsigned & w_raw[15]}}, w_raw[15:0]};
            MEM_W:   ld_data = w_raw;
            default: ld_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Load/store unit mapping one request onto one or two bus beats.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import lsu_pkg::*;
#(
    parameter int BUS_W            = 32,
    parameter int ADDR_W           = 32,
    parameter int SPLIT_MISALIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_sl_type,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_misaligned,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BUS_W-1:0]     mem_wdata,
    output logic [BUS_W/8-1:0]   mem_wstrb,
    input  logic                 mem_rsp_valid,
    input  logic [BUS_W-1:0]     mem_rdata
);

    localparam int c_NB    = BUS_W / 8;
    localparam int c_OFF_W = $clog2(c_NB);

    lsu_state_e           r_state;
    logic [3:0]           r_type;
    logic [c_OFF_W-1:0]   r_off;
    logic [31:0]          r_wdata;
    logic [BUS_W-1:0]     r_beat0;
    logic                 r_cross;

    logic                 w_idle;
    logic [c_OFF_W-1:0]   w_off;
    logic [1:0]           w_size;
    logic [31:0]          w_wdata;
    logic [2:0]           w_nbytes;
    logic [4:0]           w_end;
    logic                 w_cross;
    logic                 w_nop;
    logic                 w_fault;
    logic [ADDR_W-1:0]    w_aligned;
    logic [BUS_W-1:0]     w_beat0;
    logic [BUS_W-1:0]     w_st_data0;
    logic [BUS_W-1:0]     w_st_data1;
    logic [c_NB-1:0]      w_st_strb0;
    logic [c_NB-1:0]      w_st_strb1;
    logic [31:0]          w_ld_data;
    logic [31:0]          w_rsp_data;

    // The aligner sees the incoming request in IDLE and the latched one afterwards
    assign w_idle    = (r_state == IDLE);
    assign w_off     = w_idle ? req_addr[c_OFF_W-1:0] : r_off;
    assign w_size    = w_idle ? req_sl_type[1:0]      : r_type[1:0];
    assign w_wdata   = w_idle ? req_wdata             : r_wdata;
    assign w_nbytes  = lsu_nbytes(w_size);
    assign w_end     = 5'(w_off) + 5'(w_nbytes);
    assign w_cross   = (w_end > 5'(c_NB));
    assign w_nop     = (req_sl_type[1:0] == MEM_NOP);
    assign w_aligned = {req_addr[ADDR_W-1:c_OFF_W], {c_OFF_W{1'b0}}};
    assign w_beat0   = (r_state == WAIT0) ? mem_rdata : r_beat0;
    assign w_rsp_data = r_type[SL_STORE] ? 32'd0 : w_ld_data;

    always_comb begin
        w_fault = 1'b0;
        if (SPLIT_MISALIGNED == 0) begin
            case (req_sl_type[1:0])
                MEM_H:   w_fault = req_addr[0];
                MEM_W:   w_fault = |req_addr[1:0];
                default: w_fault = 1'b0;
            endcase
        end
    end

    mem_lane_align #(
        .BUS_W (BUS_W)
    ) u_align (
        .off         (w_off),
        .size        (w_size),
        .is_unsigned (r_type[SL_UNSIGNED]),
        .wdata       (w_wdata),
        .beat0       (w_beat0),
        .beat1       (mem_rdata),
        .st_data0    (w_st_data0),
        .st_data1    (w_st_data1),
        .st_strb0    (w_st_strb0),
        .st_strb1    (w_st_strb1),
        .ld_data     (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_misaligned <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_wstrb      <= '0;
            r_type         <= '0;
            r_off          <= '0;
            r_wdata        <= '0;
            r_beat0        <= '0;
            r_cross        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_type    <= req_sl_type;
                        r_off     <= req_addr[c_OFF_W-1:0];
                        r_wdata   <= req_wdata;
                        r_cross   <= w_cross;
                        req_ready <= 1'b0;
                        if (w_nop || w_fault) begin
                            r_state        <= RESP;
                            rsp_valid      <= 1'b1;
                            rsp_rdata      <= '0;
                            rsp_misaligned <= w_fault;
                        end else begin
                            r_state       <= REQ0;
                            mem_req_valid <= 1'b1;
                            mem_we        <= req_sl_type[SL_STORE];
                            mem_addr      <= w_aligned;
                            mem_wdata     <= req_sl_type[SL_STORE] ? w_st_data0 : '0;
                            mem_wstrb     <= req_sl_type[SL_STORE] ? w_st_strb0 : '0;
                        end
                    end
                end
                REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= WAIT0;
                    end
                end
                WAIT0: begin
                    if (mem_rsp_valid) begin
                        r_beat0 <= mem_rdata;
                        if (r_cross) begin
                            r_state       <= REQ1;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= mem_addr + ADDR_W'(c_NB);
                            mem_wdata     <= r_type[SL_STORE] ? w_st_data1 : '0;
                            mem_wstrb     <= r_type[SL_STORE] ? w_st_strb1 : '0;
                        end else begin
                            r_state   <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= w_rsp_data;
                        end
                    end
                end
                REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= WAIT1;
                    end
                end
                WAIT1: begin
                    if (mem_rsp_valid) begin
                        r_state   <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= w_rsp_data;
                    end
                end
                RESP: begin
                    r_state        <= IDLE;
                    req_ready      <= 1'b1;
                    rsp_valid      <= 1'b0;
                    rsp_rdata      <= '0;
                    rsp_misaligned <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
